ifetch_queue: RTL

//  - Instruction fetch front end: owns the PC, issues sequential word fetches to instruction memory, buffers returned words.
//  - Presents {instr, pc} to the decode stage (opcode/immediate extraction) over a valid/ready handshake.
//  - Absorbs decode stalls; flushes on branch/jump redirect from execute.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/ifq_fifo.sv | 65 ++++++
 rtl/ifetch_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants: word widths, PC step, NOP encoding, queue entry layout.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } ifq_entry_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue storage: DEPTH x {instr, pc} ring buffer with push/pop/clear.
// Latency: push visible at head the cycle after; clear wins over push and pop.
// Backpressure: push ignored when full unless popping; pop ignored when empty.
module ifq_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  ifq_entry_t             push_dat,
    input  logic                   pop,
    output ifq_entry_t             head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifq_entry_t      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the PC, issues one word fetch per cycle under a credit limit, queues {instr, pc} for decode.
// Latency: request N -> id_valid N+2 (N+1 when built with IFQ_BYPASS_EN and the queue is empty).
// Backpressure: decode stalls hold the head; fetch stops once queued + in-flight words reach DEPTH.
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight;
    logic            en_q;
    logic [CW-1:0]   count;
    logic            empty;
    logic [CW:0]     occ;
    logic            accept;
    logic            push;
    logic            pop;
    ifq_entry_t      head;
    ifq_entry_t      resp;

    // Credit: every outstanding request already owns a queue slot.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = en_q && !redirect_valid && (occ < DEPTH_C);
    assign imem_addr = pc_q;

    // Responses only count when we are waiting for one and no flush is in progress.
    assign accept = imem_rvalid && inflight && !redirect_valid;
    assign resp   = {imem_rdata, req_pc_q};

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass   = empty && accept;
    assign push     = accept && !(bypass && id_ready);
    assign id_valid = !empty || bypass;
    assign id_instr = bypass ? imem_rdata : head.instr;
    assign id_pc    = bypass ? req_pc_q   : head.pc;
`else
    assign push     = accept;
    assign id_valid = !empty;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;
`endif

    assign pop = id_valid && id_ready && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_RESET;
            req_pc_q <= PC_RESET;
            inflight <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            en_q     <= 1'b1;
            inflight <= imem_req;
            if (redirect_valid) begin
                pc_q <= align_pc(redirect_pc);
            end else if (imem_req) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (imem_req) begin
                req_pc_q <= pc_q;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (redirect_valid),
        .push     (push),
        .push_dat (resp),
        .pop      (pop),
        .head_dat (head),
        .count    (count),
        .empty    (empty)
    );

    // With a fixed one-cycle memory, a response can only follow our own request.
    assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> inflight);

endmodule
